// File: rtl/cmp_bist_if.sv
// Operand/response bundle between the comparator BIST engine and the comparator under test.
interface cmp_bist_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             equal_i;
  logic             gt_i;
  logic             lt_i;

  modport master (output a_o, output b_o, input equal_i, input gt_i, input lt_i);
  modport slave  (input a_o, input b_o, output equal_i, output gt_i, output lt_i);
endinterface

// File: rtl/cmp_bist.sv
// Exhaustive sweep generator and response checker for an equal/gt/lt magnitude comparator.
// state | meaning
// IDLE  | waiting for the first start, operands held at zero
// RUN   | one operand pair driven per cycle, a-major / b-minor
// DRAIN | last vector held while its response works through the latency
// DONE  | results frozen, operands at zero, start restarts the sweep
module cmp_bist #(
  parameter int WIDTH = 2,
  parameter int LAT   = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  cmp_bist_if.master       cmp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);
  localparam int IW = 2 * WIDTH;
  localparam logic [IW-1:0] IDX_LAST = '1;
  localparam logic [1:0] DRAIN_LOAD = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [1:0]       drain_cnt;
  logic             launch;
  logic [2:0]       exp_now;
  logic [2:0]       resp;
  logic             chk_valid;
  logic [2:0]       chk_exp;
  logic [WIDTH-1:0] chk_a, chk_b;

  assign cmp.a_o = idx[IW-1:WIDTH];
  assign cmp.b_o = idx[WIDTH-1:0];
  assign exp_now = {cmp.a_o == cmp.b_o, cmp.a_o > cmp.b_o, cmp.a_o < cmp.b_o};
  assign resp    = {cmp.equal_i, cmp.gt_i, cmp.lt_i};
  assign pass    = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        launch    = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == IDX_LAST) state_nxt = (LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd0) state_nxt = DONE;
      end
      DONE: if (start) begin
        state_nxt = RUN;
        launch    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx holds the last vector through DRAIN and only clears once the sweep is over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      drain_cnt <= 2'd0;
    end else begin
      case (state_nxt)
        RUN:     idx <= (state == RUN) ? idx + IW'(1) : '0;
        DRAIN:   idx <= idx;
        default: idx <= '0;
      endcase
      if (state == RUN)
        drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  if (LAT > 0) begin : g_pipe
    logic [LAT-1:0]   pv;
    logic [2:0]       pe [LAT];
    logic [WIDTH-1:0] pa [LAT];
    logic [WIDTH-1:0] pb [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int i = 0; i < LAT; i++) begin
          pe[i] <= '0;
          pa[i] <= '0;
          pb[i] <= '0;
        end
      end else begin
        pv[0] <= (state == RUN);
        pe[0] <= exp_now;
        pa[0] <= cmp.a_o;
        pb[0] <= cmp.b_o;
        for (int i = 1; i < LAT; i++) begin
          pv[i] <= pv[i-1];
          pe[i] <= pe[i-1];
          pa[i] <= pa[i-1];
          pb[i] <= pb[i-1];
        end
      end
    end

    assign chk_valid = pv[LAT-1];
    assign chk_exp   = pe[LAT-1];
    assign chk_a     = pa[LAT-1];
    assign chk_b     = pb[LAT-1];
  end else begin : g_comb
    assign chk_valid = (state == RUN);
    assign chk_exp   = exp_now;
    assign chk_a     = cmp.a_o;
    assign chk_b     = cmp.b_o;
  end

  // done lags entry into DONE by one cycle so it follows the final check's result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      done       <= 1'b0;
    end else if (launch) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      done       <= 1'b0;
    end else begin
      if (chk_valid && (resp != chk_exp)) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= chk_a;
          fail_b     <= chk_b;
        end
      end
      if (state == DONE) done <= 1'b1;
    end
  end
endmodule

// File: doc/cmp_bist.md
Name: cmp_bist

Overview:
- Hardware stimulus generator and checker for a magnitude comparator that exposes equal/gt/lt outputs.
- Sweeps every (a, b) operand pair in ascending order: a-major, b-minor, i.e. 00/00, 00/01 … 11/11 for WIDTH=2.
- Drives the comparator under test, samples its response after a fixed latency, and checks it against an internally computed golden result.
- Reports pass/fail, an error count and the first failing vector. Used as on-chip BIST and as a reusable self-checking driver in comparator benches.

Parameters:
- WIDTH, 2, operand width of the comparator under test (1..8).
- LAT, 1, response latency of the DUT in clock cycles (0..3); 0 = purely combinational DUT.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; sampled in IDLE or DONE only.
- a_o  out  WIDTH  operand a to DUT.
- b_o  out  WIDTH  operand b to DUT.
- equal_i  in  1  DUT a==b.
- gt_i  in  1  DUT a>b.
- lt_i  in  1  DUT a<b.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  ERR_W  mismatching vectors, saturating at all-ones.
- fail_valid  out  1  at least one mismatch recorded.
- fail_a  out  WIDTH  a of first mismatching vector.
- fail_b  out  WIDTH  b of first mismatching vector.

Behaviour:
- Reset (async, rst_n low): state=IDLE; a_o, b_o, err_cnt, fail_a, fail_b = 0; busy, done, pass, fail_valid = 0. Expected-result pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN.
  - RUN --last vector driven--> DRAIN if LAT>0, else DONE.
  - DRAIN --LAT cycles elapsed--> DONE.
  - DONE --start--> RUN.
- Entering RUN from IDLE or DONE clears err_cnt, fail_valid, fail_a, fail_b and done.
- Vector index idx is 2*WIDTH bits: a_o = idx[2W-1:W], b_o = idx[W-1:0]. idx starts at 0 and increments once per RUN cycle. Exactly 2^(2*WIDTH) vectors are driven, one per cycle, with no gaps.
- Timing: with start sampled high at edge E0, vector k is driven during cycle k+1 after E0.
- Golden result per vector: exp = {a==b, a>b, a<b}, unsigned compare. It is carried through a LAT-deep shift register with a valid bit and the vector's a/b.
- Response for vector k is sampled at the end of the LAT-th cycle after it is driven. LAT=0 samples in the same cycle.
- Mismatch when {equal_i, gt_i, lt_i} != exp. All three bits are compared, so a non-one-hot response is an error.
- On mismatch: err_cnt += 1 unless already all-ones. On the first mismatch, capture fail_a/fail_b and set fail_valid.
- After the last check, done rises on the next cycle and holds until the next start. pass is combinational from done and err_cnt.
- Total latency, start edge to done high: 2^(2*WIDTH) + LAT + 1 cycles (18 for defaults).
- a_o/b_o return to 0 in IDLE and DONE; in DRAIN they hold the last vector.
- Boundaries:
  - start in RUN/DRAIN: ignored; no restart, no counter clear.
  - start held high across DONE: restarts once, then ignored while busy.
  - idx wrap (all-ones to 0) occurs only on leaving RUN; no vector is repeated.
  - Reset mid-run: all state cleared immediately; in-flight checks discarded; the next start performs a full sweep.
  - Saturated err_cnt stays at all-ones; fail_a/fail_b remain those of the first failure.

Test Plan:
- Correct comparator, WIDTH=2, LAT=1, start pulse -> a_o/b_o step 00/00 … 11/11 over 16 cycles; done high 18 cycles after start; err_cnt=0; pass=1; fail_valid=0.
- DUT with gt/lt swapped -> err_cnt=12; fail_valid=1; fail_a=0, fail_b=1; pass=0 once done.
- DUT with equal stuck at 0 -> err_cnt=4; fail_a=0, fail_b=0.
- ERR_W=3 with DUT outputs stuck at 000 -> err_cnt saturates at 7; fail_a=fail_b=0.
- start pulsed at vector 5 of a run -> sweep continues unchanged, done still at cycle 18; a second start in DONE -> err_cnt cleared, full 16-vector sweep repeats.
- rst_n low at vector 7 -> all outputs 0 asynchronously, state IDLE; next start gives full sweep and pass=1. Repeat with LAT=0 -> done 17 cycles after start.
